// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - scan states, hex glyph table and digit-enable patterns for seg7_scan_ctrl
package seg7_pkg;

    // Blank guard slot followed by lit slot, for each of the three digits.
    typedef enum logic [2:0] {
        BLK0 = 3'd0,
        ON0  = 3'd1,
        BLK1 = 3'd2,
        ON1  = 3'd3,
        BLK2 = 3'd4,
        ON2  = 3'd5
    } scan_state_t;

    // Segment order abcdefg (bit 6 = a). A 1 means the segment is lit; the
    // top level inverts for the common-anode pins.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    // Active-low enables, ordered {e0, e1, e2}.
    localparam logic [2:0] EN_NONE = 3'b111;
    localparam logic [2:0] EN_DIG0 = 3'b011;
    localparam logic [2:0] EN_DIG1 = 3'b101;
    localparam logic [2:0] EN_DIG2 = 3'b110;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic scan_state_t next_state(input scan_state_t s);
        case (s)
            BLK0:    return ON0;
            ON0:     return BLK1;
            BLK1:    return ON1;
            ON1:     return BLK2;
            BLK2:    return ON2;
            default: return BLK0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational hex digit to seven-segment decode
// Ports: digit (4-bit hex in), lit (abcdefg, 1 = segment lit)
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] lit
);

    assign lit = GLYPH_TABLE[digit];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - three-digit multiplexed seven-segment scanner with frame-synchronous load
// Ports: clk, rst_n (async active-low), value/dp/load_valid/load_ready (load handshake),
//        e0..e2 (active-low digit enables), a..g/dot (active-low segments), frame_tick.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIV   = 16000,
    parameter int BLANK = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] value,
    input  logic [2:0]  dp,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        e0,
    output logic        e1,
    output logic        e2,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dot,
    output logic        frame_tick
);

    localparam logic [15:0] BLK_LAST = 16'(BLANK - 1);
    localparam logic [15:0] ON_LAST  = 16'(DIV - BLANK - 1);
    // frame_tick is registered, so it is raised one clock before the last ON2 clock.
    localparam logic [15:0] TICK_PRE = 16'(DIV - BLANK - 2);

    scan_state_t state;
    logic [15:0] cnt;
    logic        tick_q;

    logic [11:0] act_val;
    logic [2:0]  act_dp;
    logic [11:0] pend_val;
    logic [2:0]  pend_dp;
    logic        pend_full;

    logic [2:0]  en_q;
    logic [6:0]  seg_q;
    logic        dot_q;

    logic        is_on;
    logic        slot_last;
    logic [3:0]  cur_digit;
    logic        cur_dp;
    logic        cur_blank;
    logic [2:0]  cur_en;
    logic [6:0]  cur_lit;
    logic        lz_dig0;
    logic        lz_dig1;
    logic        accept;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign lz_dig0 = (act_val[11:8] == 4'd0);
    assign lz_dig1 = lz_dig0 && (act_val[7:4] == 4'd0);
`else
    assign lz_dig0 = 1'b0;
    assign lz_dig1 = 1'b0;
`endif

    assign is_on     = state inside {ON0, ON1, ON2};
    assign slot_last = is_on ? (cnt == ON_LAST) : (cnt == BLK_LAST);
    assign accept    = load_valid && !pend_full;

    always_comb begin
        cur_digit = act_val[11:8];
        cur_dp    = act_dp[2];
        cur_blank = lz_dig0;
        cur_en    = EN_DIG0;
        case (state)
            BLK1, ON1: begin
                cur_digit = act_val[7:4];
                cur_dp    = act_dp[1];
                cur_blank = lz_dig1;
                cur_en    = EN_DIG1;
            end
            BLK2, ON2: begin
                cur_digit = act_val[3:0];
                cur_dp    = act_dp[0];
                cur_blank = 1'b0;
                cur_en    = EN_DIG2;
            end
            default: begin
                cur_digit = act_val[11:8];
                cur_dp    = act_dp[2];
                cur_blank = lz_dig0;
                cur_en    = EN_DIG0;
            end
        endcase
    end

    seg7_glyph u_glyph (
        .digit (cur_digit),
        .lit   (cur_lit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLK0;
            cnt       <= '0;
            tick_q    <= 1'b0;
            en_q      <= EN_NONE;
            seg_q     <= SEG_OFF;
            dot_q     <= 1'b1;
            act_val   <= '0;
            act_dp    <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
        end else begin
            if (slot_last) begin
                state <= next_state(state);
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            tick_q <= (state == ON2) && (cnt == TICK_PRE);

            if (is_on) begin
                en_q  <= cur_en;
                seg_q <= cur_blank ? SEG_OFF : ~cur_lit;
                dot_q <= ~cur_dp;
            end else begin
                en_q  <= EN_NONE;
                seg_q <= SEG_OFF;
                dot_q <= 1'b1;
            end

            // Active only changes on the frame boundary so a frame never mixes
            // two loads. A load landing on that boundary bypasses pending.
            if (tick_q) begin
                if (accept) begin
                    act_val <= value;
                    act_dp  <= dp;
                end else if (pend_full) begin
                    act_val   <= pend_val;
                    act_dp    <= pend_dp;
                    pend_full <= 1'b0;
                end
            end else if (accept) begin
                pend_val  <= value;
                pend_dp   <= dp;
                pend_full <= 1'b1;
            end
        end
    end

    assign load_ready = !pend_full;
    assign frame_tick = tick_q;
    assign {e0, e1, e2}          = en_q;
    assign {a, b, c, d, e, f, g} = seg_q;
    assign dot                   = dot_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl with DIV=8, BLANK=2
module tb_seg7_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    // Active-low glyphs, abcdefg, written out by hand.
    localparam logic [6:0] GN [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] value;
    logic [2:0]  dp;
    logic        load_valid;
    logic        load_ready;
    logic        e0, e1, e2;
    logic        a, b, c, d, e, f, g;
    logic        dot;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];

    seg7_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .e0         (e0),
        .e1         (e1),
        .e2         (e2),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .g          (g),
        .dot        (dot),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] exp_slot(input logic [11:0] v, input logic [2:0] p, input int n);
        logic [3:0] dig;
        logic       blank;
        logic [2:0] en;
        dig   = v[4*(2-n) +: 4];
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (n == 0) blank = (v[11:8] == 4'd0);
        if (n == 1) blank = (v[11:4] == 8'd0);
`endif
        en = (n == 0) ? 3'b011 : (n == 1) ? 3'b101 : 3'b110;
        return {en, blank ? 7'b1111111 : GN[dig], ~p[2-n]};
    endfunction

    task automatic push_frame(input logic [11:0] v, input logic [2:0] p);
        for (int n = 0; n < 3; n++) exp_q.push_back(exp_slot(v, p, n));
    endtask

    task automatic wait_tick();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (frame_tick) got = 1'b1;
        end
        chk("tick_wait", 32'(got), 32'd1);
    endtask

    // Called at a negedge; drops valid once the handshake edge has passed.
    task automatic do_load(input logic [11:0] v, input logic [2:0] p);
        bit done;
        done       = 1'b0;
        value      = v;
        dp         = p;
        load_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            if (load_ready) done = 1'b1;
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk("load_accept", 32'(done), 32'd1);
    endtask

    task automatic chk_dark(input string name);
        chk({name, "_en"},   32'({e0, e1, e2}), 32'b111);
        chk({name, "_seg"},  32'({a, b, c, d, e, f, g}), 32'h7F);
        chk({name, "_dot"},  32'(dot), 32'd1);
        chk({name, "_tick"}, 32'(frame_tick), 32'd0);
        chk({name, "_rdy"},  32'(load_ready), 32'd1);
    endtask

    // Monitor: pops one expected pattern at the start of each lit slot and
    // checks slot lengths, blank contents and frame_tick spacing.
    initial begin : monitor
        logic [2:0]  prev_en;
        logic [2:0]  en_s;
        logic [10:0] slot_val;
        logic [10:0] cur;
        int          since, last_tick, on_len, blk_len;
        bit          first_blk;
        prev_en = 3'b111; since = -1; last_tick = -1; on_len = 0; blk_len = 0; first_blk = 1'b1;
        slot_val = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 3'b111; since = -1; last_tick = -1;
                on_len = 0; blk_len = 0; first_blk = 1'b1;
            end else begin
                since++;
                if (frame_tick) begin
                    chk("tick_period", 32'(since - last_tick), 32'(3 * DIV));
                    last_tick = since;
                end
                en_s = {e0, e1, e2};
                cur  = {e0, e1, e2, a, b, c, d, e, f, g, dot};
                if (en_s != 3'b111) begin
                    if (prev_en == 3'b111) begin
                        if (!first_blk) chk("blank_len", 32'(blk_len), 32'(BLANK));
                        first_blk = 1'b0;
                        blk_len   = 0;
                        on_len    = 1;
                        slot_val  = cur;
                        if (exp_q.size() > 0) chk("slot_pattern", 32'(cur), 32'(exp_q.pop_front()));
                    end else begin
                        on_len++;
                        chk("slot_stable", 32'(cur), 32'(slot_val));
                    end
                end else begin
                    if (prev_en != 3'b111) chk("on_len", 32'(on_len), 32'(DIV - BLANK));
                    blk_len++;
                    chk("blank_seg_dot", 32'({a, b, c, d, e, f, g, dot}), 32'hFF);
                end
                prev_en = en_s;
            end
        end
    end

    initial begin : stimulus
        bit seen;
        rst_n      = 1'b0;
        value      = '0;
        dp         = '0;
        load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_dark("reset");
        push_frame(12'h000, 3'b000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle load lands in pending; shown only after the next tick.
        wait_tick();
        push_frame(12'h000, 3'b000);
        @(negedge clk);
        do_load(12'h3A7, 3'b010);
        chk("pending_full_ready", 32'(load_ready), 32'd0);
        wait_tick();
        push_frame(12'h3A7, 3'b010);

        // Back-to-back: the second load stalls until the boundary.
        @(negedge clk);
        do_load(12'h111, 3'b000);
        value      = 12'h222;
        dp         = 3'b000;
        load_valid = 1'b1;
        @(negedge clk);
        chk("stall_ready", 32'(load_ready), 32'd0);
        wait_tick();
        chk("stall_at_tick", 32'(load_ready), 32'd0);
        push_frame(12'h111, 3'b000);
        do_load(12'h222, 3'b000);
        wait_tick();
        push_frame(12'h222, 3'b000);

        // Load offered exactly on the tick goes straight to active.
        wait_tick();
        push_frame(12'hFFF, 3'b000);
        chk("tick_load_ready_before", 32'(load_ready), 32'd1);
        value      = 12'hFFF;
        dp         = 3'b000;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk("tick_load_ready_after", 32'(load_ready), 32'd1);

        // Leading zeros, with a decimal point on digit0.
        @(negedge clk);
        do_load(12'h005, 3'b100);
        wait_tick();
        push_frame(12'h005, 3'b100);

        // Reset during ON1 with a pending load outstanding.
        @(negedge clk);
        do_load(12'hABC, 3'b011);
        chk("pending_before_reset", 32'(load_ready), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (!e1) seen = 1'b1;
        end
        chk("reach_on1", 32'(seen), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_dark("reset_mid");
        exp_q.delete();
        push_frame(12'h000, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_tick();
        push_frame(12'h000, 3'b000);
        wait_tick();
        push_frame(12'h000, 3'b000);
        wait_tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 16000: clocks per digit slot (12 MHz clock gives 750 Hz per slot, 250 Hz per frame); legal range 4..65535.
REQ-002 SHALL have parameter BLANK, default 64: leading all-off clocks per slot, as a ghosting guard; legal range 1..DIV-2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port value, input, 12 bits: three hex digits; [11:8] is digit0 (e0, left), [3:0] is digit2 (e2, right).
REQ-006 SHALL have port dp, input, 3 bits: active-high decimal point request per digit; bit 2 is digit0.
REQ-007 SHALL have port load_valid, input, 1 bit: value and dp are offered.
REQ-008 SHALL have port load_ready, output, 1 bit: pending buffer empty.
REQ-009 SHALL have ports e0, e1, e2, output, 1 bit each: active-low digit enables.
REQ-010 SHALL have ports a, b, c, d, e, f, g, output, 1 bit each: active-low segments (common anode).
REQ-011 SHALL have port dot, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse on the last clock of the digit2 slot.

Function
REQ-013 SHALL cycle through FSM states BLK0, ON0, BLK1, ON1, BLK2, ON2, then back to BLK0; BLKn lasts BLANK clocks and ONn lasts DIV-BLANK clocks, using one slot counter that reloads on every state change.
REQ-014 SHALL, in every BLKn state, drive e0, e1, e2 = 111, all segments = 1111111 and dot = 1.
REQ-015 SHALL, in ONn, drive only digit n's enable low; segments and dot come from active digit n.
REQ-016 SHALL register all display outputs, with a fixed one-clock latency from state to pins.
REQ-017 SHALL decode hex digits with standard 0-F glyphs (A, b, C, d, E, F); segment order is abcdefg, and 1 means lit before inversion.
REQ-018 SHALL accept a load when load_valid and load_ready are both 1; value and dp are then captured into the pending buffer and load_ready drops.
REQ-019 SHALL copy pending into active, and set load_ready = 1, on a frame_tick cycle when pending is full, so that no frame shows mixed data.
REQ-020 SHALL, when a load is accepted on a frame_tick cycle, write the load straight into active and leave pending empty.
REQ-021 SHALL keep load_ready low, with the accepted value held, while load_valid is held during a full pending buffer; it SHALL never overwrite pending.
REQ-022 SHALL wrap the counter and FSM from ON2 to BLK0 with no idle clock; the frame period is exactly 3*DIV clocks.

Reset
REQ-023 SHALL, while rst_n = 0, immediately force e0, e1, e2 = 111, segments = 1111111, dot = 1, frame_tick = 0 and load_ready = 1.
REQ-024 SHALL clear active and pending to 0 and set the state to BLK0 with counter = 0; after release, ON0 starts at clock BLANK.
REQ-025 SHALL, on reset mid-slot or mid-handshake, discard any pending data; no glyph is driven until the first ON0.

Configuration
REQ-026 SHALL, with SEG7_LEADING_ZERO_BLANK_EN defined, blank digit0 when it is 0, and blank digit1 when digit0 and digit1 are both 0; digit2 is never blanked; dp still drives dot on a blanked digit.
REQ-027 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, display all three digits, including leading 0.

Structure
REQ-028 SHALL place the FSM state enum, the 16-entry glyph constant table and the enable-pattern constants in package seg7_pkg.
REQ-029 SHALL use one sub-module, seg7_glyph: a combinational 4-bit-to-7-bit decode; the FSM, counter and handshake stay in seg7_scan_ctrl.

Verification (DIV=8, BLANK=2)
REQ-030 SHALL check reset release: e0, e1, e2 = 111 for 2 clocks, then e0 = 0 with segments 0000001 (glyph 0) for 6 clocks; frame_tick first pulses at clock 23.
REQ-031 SHALL check load of value=12'h3A7 with dp=3'b010 while idle: ON0 shows 0000110, ON1 shows 0001000 with dot=0, ON2 shows 0001111, all after the next frame_tick.
REQ-032 SHALL check back-to-back loads 12'h111 then 12'h222: the second stalls (load_ready=0) until frame_tick; the displayed sequence is 111 then 222 with no mixed frame.
REQ-033 SHALL check a load asserted exactly on frame_tick: value 12'hFFF appears in the immediately following ON0, and load_ready stays 1.
REQ-034 SHALL check rst_n pulsed low during ON1: outputs go to 111 / 1111111 the same clock, and pending is lost.
REQ-035 SHALL check value=12'h005 with SEG7_LEADING_ZERO_BLANK_EN: digits 0 and 1 are dark and digit2 shows 0100100; without the macro, 0, 0, 5 is shown.
